asteroide_datapath: RTL and testbench

- Datapath for one asteroid field of the AstroGenius game.
- Holds a 16-slot asteroid table (position, loaded flag, destroyed flag), the ship position register and a slot counter.
- Has a ±1 adder/subtractor that moves either the ship or the current asteroid one cell.
- Reports collisions between the ship and the addressed asteroid.
- Driven cycle by cycle by the game controller FSM, which sits outside this block.

---
 rtl/asteroide_datapath.sv | 108 ++++++++++
 tb/tb_asteroide_datapath.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asteroide_datapath.sv
// Datapath for one asteroid field: a 16-slot asteroid table, the ship register,
// a slot counter and the +/-1 coordinate unit, all sequenced by an external controller.
module asteroide_datapath #(
  parameter int                     COORD_W      = 4,
  parameter logic [2*COORD_W-1:0]   SHIP_INIT    = 8'h77,
  parameter logic [31:0]            OPCODE_TABLE = 32'hE4E4E4E4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               conta_contador,
  input  logic               reset_cont,
  input  logic [1:0]         select_mux_pos,
  input  logic               select_mux_coor,
  input  logic               select_soma_sub,
  input  logic               enable_reg_nave,
  input  logic               reset_reg_nave,
  input  logic               enable_mem_aste,
  input  logic               enable_mem_load,
  input  logic               new_load,
  input  logic               new_destruido,
  output logic               colisao,
  output logic               rco_contador,
  output logic [1:0]         opcode,
  output logic               destruido,
  output logic               loaded,
  output logic [3:0]         db_contador,
  output logic [COORD_W:0]   db_wire_saida_som_sub
);

  localparam int POS_W = 2 * COORD_W;
  localparam int SLOTS = 16;
  localparam logic [COORD_W:0] ONE = 1;

  logic [3:0]         cnt;
  logic [POS_W-1:0]   ship;
  logic [POS_W-1:0]   ast_pos [SLOTS];
  logic [SLOTS-1:0]   ast_loaded;
  logic [SLOTS-1:0]   ast_destr;

  logic [POS_W-1:0]   cur_pos;
  logic [POS_W-1:0]   base;
  logic [POS_W-1:0]   moved;
  logic [POS_W-1:0]   mux_pos;
  logic [COORD_W-1:0] operand;
  logic [COORD_W:0]   sum;

  // Position is {x, y}; the add/sub works on one coordinate of either the ship
  // or the addressed asteroid and wraps it back into the same field.
  always_comb begin
    cur_pos = ast_pos[cnt];
    base    = (select_mux_pos == 2'b01 || select_mux_pos == 2'b10) ? ship : cur_pos;
    operand = select_mux_coor ? base[COORD_W-1:0] : base[POS_W-1:COORD_W];
    sum     = select_soma_sub ? ({1'b0, operand} - ONE) : ({1'b0, operand} + ONE);
    moved   = select_mux_coor ? {base[POS_W-1:COORD_W], sum[COORD_W-1:0]}
                              : {sum[COORD_W-1:0], base[COORD_W-1:0]};
    case (select_mux_pos)
      2'b00:   mux_pos = cur_pos;
      2'b01:   mux_pos = ship;
      default: mux_pos = moved;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (reset_cont) begin
      cnt <= '0;
    end else if (conta_contador) begin
      cnt <= cnt + 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || reset_reg_nave) begin
      ship <= SHIP_INIT;
    end else if (enable_reg_nave) begin
      ship <= mux_pos;
    end
  end

  // Writes use the counter value from before this edge, even when it increments.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SLOTS; i++) begin
        ast_pos[i] <= '0;
      end
      ast_loaded <= '0;
      ast_destr  <= '0;
    end else begin
      if (enable_mem_aste) begin
        ast_pos[cnt] <= mux_pos;
      end
      if (enable_mem_load) begin
        ast_loaded[cnt] <= new_load;
        ast_destr[cnt]  <= new_destruido;
      end
    end
  end

  assign colisao               = (cur_pos == ship) && ast_loaded[cnt] && !ast_destr[cnt];
  assign rco_contador          = (cnt == 4'hF);
  assign opcode                = OPCODE_TABLE[{cnt, 1'b0} +: 2];
  assign destruido             = ast_destr[cnt];
  assign loaded                = ast_loaded[cnt];
  assign db_contador           = cnt;
  assign db_wire_saida_som_sub = sum;

endmodule

// File: tb/tb_asteroide_datapath.sv
// Self-checking bench for asteroide_datapath: directed scenarios plus randomized
// control sequences compared against an arithmetic model of the asteroid field.
module tb_asteroide_datapath;

  logic       clock = 1'b0;
  logic       reset;
  logic       conta_contador;
  logic       reset_cont;
  logic [1:0] select_mux_pos;
  logic       select_mux_coor;
  logic       select_soma_sub;
  logic       enable_reg_nave;
  logic       reset_reg_nave;
  logic       enable_mem_aste;
  logic       enable_mem_load;
  logic       new_load;
  logic       new_destruido;
  logic       colisao;
  logic       rco_contador;
  logic [1:0] opcode;
  logic       destruido;
  logic       loaded;
  logic [3:0] db_contador;
  logic [4:0] db_wire_saida_som_sub;

  int checks = 0;
  int passes = 0;

  // Model state: positions held as integers 16*x + y.
  int m_cnt;
  int m_ship;
  int m_pos [16];
  bit m_ld  [16];
  bit m_ds  [16];

  asteroide_datapath dut (
    .clock                 (clock),
    .reset                 (reset),
    .conta_contador        (conta_contador),
    .reset_cont            (reset_cont),
    .select_mux_pos        (select_mux_pos),
    .select_mux_coor       (select_mux_coor),
    .select_soma_sub       (select_soma_sub),
    .enable_reg_nave       (enable_reg_nave),
    .reset_reg_nave        (reset_reg_nave),
    .enable_mem_aste       (enable_mem_aste),
    .enable_mem_load       (enable_mem_load),
    .new_load              (new_load),
    .new_destruido         (new_destruido),
    .colisao               (colisao),
    .rco_contador          (rco_contador),
    .opcode                (opcode),
    .destruido             (destruido),
    .loaded                (loaded),
    .db_contador           (db_contador),
    .db_wire_saida_som_sub (db_wire_saida_som_sub)
  );

  always #5 clock = ~clock;

  function automatic int m_base();
    return (select_mux_pos == 2'd1 || select_mux_pos == 2'd2) ? m_ship : m_pos[m_cnt];
  endfunction

  function automatic int m_sum();
    int b, c;
    b = m_base();
    c = select_mux_coor ? (b % 16) : (b / 16);
    return select_soma_sub ? (c + 31) % 32 : (c + 1) % 32;
  endfunction

  function automatic int m_mux();
    int b, nc;
    b  = m_base();
    nc = m_sum() % 16;
    if (select_mux_pos == 2'd0) return m_pos[m_cnt];
    if (select_mux_pos == 2'd1) return m_ship;
    return select_mux_coor ? ((b / 16) * 16 + nc) : (nc * 16 + (b % 16));
  endfunction

  function automatic bit m_colisao();
    return (m_pos[m_cnt] == m_ship) && m_ld[m_cnt] && !m_ds[m_cnt];
  endfunction

  task automatic model_update();
    int mux, a;
    if (reset) begin
      m_cnt  = 0;
      m_ship = 8'h77;
      for (int i = 0; i < 16; i++) begin
        m_pos[i] = 0; m_ld[i] = 0; m_ds[i] = 0;
      end
    end else begin
      mux = m_mux();
      a   = m_cnt;
      if (reset_reg_nave)       m_ship = 8'h77;
      else if (enable_reg_nave) m_ship = mux;
      if (enable_mem_aste) m_pos[a] = mux;
      if (enable_mem_load) begin
        m_ld[a] = new_load; m_ds[a] = new_destruido;
      end
      if (reset_cont)          m_cnt = 0;
      else if (conta_contador) m_cnt = (m_cnt + 1) % 16;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic drive_idle();
    reset = 0; conta_contador = 0; reset_cont = 0; select_mux_pos = 2'd0;
    select_mux_coor = 0; select_soma_sub = 0; enable_reg_nave = 0; reset_reg_nave = 0;
    enable_mem_aste = 0; enable_mem_load = 0; new_load = 0; new_destruido = 0;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    #1;
    checks++; if (colisao !== 1'b0) $display("[TB] FAIL reset_colisao got=%b exp=0", colisao); else passes++;
    checks++; if (rco_contador !== 1'b0) $display("[TB] FAIL reset_rco got=%b exp=0", rco_contador); else passes++;
    checks++; if (opcode !== 2'b00) $display("[TB] FAIL reset_opcode got=%b exp=00", opcode); else passes++;
    checks++; if (destruido !== 1'b0) $display("[TB] FAIL reset_destruido got=%b exp=0", destruido); else passes++;
    checks++; if (loaded !== 1'b0) $display("[TB] FAIL reset_loaded got=%b exp=0", loaded); else passes++;
    checks++; if (db_contador !== 4'd0) $display("[TB] FAIL reset_cnt got=%h exp=0", db_contador); else passes++;
    checks++; if (db_wire_saida_som_sub !== 5'h01) $display("[TB] FAIL reset_sum got=%h exp=01", db_wire_saida_som_sub); else passes++;
    select_mux_pos = 2'd1; select_mux_coor = 0; #1;
    checks++; if (db_wire_saida_som_sub !== 5'h08) $display("[TB] FAIL reset_ship_x got=%h exp=08", db_wire_saida_som_sub); else passes++;
    select_mux_coor = 1; #1;
    checks++; if (db_wire_saida_som_sub !== 5'h08) $display("[TB] FAIL reset_ship_y got=%h exp=08", db_wire_saida_som_sub); else passes++;
  endtask

  task automatic test_ship_climb();
    int y;
    drive_idle();
    select_mux_pos = 2'd2; select_mux_coor = 1; select_soma_sub = 0;
    enable_reg_nave = 1; enable_mem_aste = 1; reset_cont = 1;
    tick();
    reset_cont = 0;
    y = 8;
    for (int i = 0; i < 8; i++) begin
      select_mux_pos = 2'd0; #1;
      checks++; if (db_wire_saida_som_sub !== 5'(y + 1)) $display("[TB] FAIL climb_ast_y%0d got=%h exp=%h", y, db_wire_saida_som_sub, 5'(y + 1)); else passes++;
      select_mux_pos = 2'd2; #1;
      checks++; if (db_wire_saida_som_sub !== 5'(y + 1)) $display("[TB] FAIL climb_ship_y%0d got=%h exp=%h", y, db_wire_saida_som_sub, 5'(y + 1)); else passes++;
      tick();
      y = (y + 1) % 16;
    end
    checks++; if (db_wire_saida_som_sub !== 5'h01) $display("[TB] FAIL climb_wrap got=%h exp=01", db_wire_saida_som_sub); else passes++;
    enable_reg_nave = 0; enable_mem_aste = 0;
  endtask

  task automatic test_collision();
    drive_idle();
    enable_mem_load = 1; new_load = 1; new_destruido = 0;
    tick();
    enable_mem_load = 0; #1;
    checks++; if (colisao !== 1'b1) $display("[TB] FAIL coll_hit got=%b exp=1", colisao); else passes++;
    checks++; if (loaded !== 1'b1) $display("[TB] FAIL coll_loaded got=%b exp=1", loaded); else passes++;
    enable_mem_load = 1; new_destruido = 1;
    tick();
    enable_mem_load = 0; #1;
    checks++; if (colisao !== 1'b0) $display("[TB] FAIL coll_destroyed got=%b exp=0", colisao); else passes++;
    checks++; if (destruido !== 1'b1) $display("[TB] FAIL coll_destruido got=%b exp=1", destruido); else passes++;
  endtask

  task automatic test_sub_wrap();
    drive_idle();
    select_mux_pos = 2'd2; select_mux_coor = 1; select_soma_sub = 1; #1;
    checks++; if (db_wire_saida_som_sub !== 5'h1F) $display("[TB] FAIL sub_borrow got=%h exp=1F", db_wire_saida_som_sub); else passes++;
    enable_reg_nave = 1;
    tick();
    enable_reg_nave = 0;
    select_mux_pos = 2'd1; select_soma_sub = 0; #1;
    checks++; if (db_wire_saida_som_sub !== 5'h10) $display("[TB] FAIL sub_ship_y15 got=%h exp=10", db_wire_saida_som_sub); else passes++;
  endtask

  task automatic test_counter();
    drive_idle();
    reset_cont = 1; tick(); reset_cont = 0;
    conta_contador = 1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      checks++; if (opcode !== 2'(i % 4)) $display("[TB] FAIL cnt_opcode%0d got=%b exp=%b", i, opcode, 2'(i % 4)); else passes++;
    end
    checks++; if (db_contador !== 4'd15) $display("[TB] FAIL cnt_15 got=%h exp=f", db_contador); else passes++;
    checks++; if (rco_contador !== 1'b1) $display("[TB] FAIL cnt_rco15 got=%b exp=1", rco_contador); else passes++;
    checks++; if (opcode !== 2'b11) $display("[TB] FAIL cnt_op15 got=%b exp=11", opcode); else passes++;
    tick();
    conta_contador = 0; #1;
    checks++; if (db_contador !== 4'd0) $display("[TB] FAIL cnt_wrap got=%h exp=0", db_contador); else passes++;
    checks++; if (rco_contador !== 1'b0) $display("[TB] FAIL cnt_rco0 got=%b exp=0", rco_contador); else passes++;
    checks++; if (opcode !== 2'b00) $display("[TB] FAIL cnt_op0 got=%b exp=00", opcode); else passes++;
  endtask

  task automatic test_asteroid_move();
    drive_idle();
    reset_cont = 1; tick(); reset_cont = 0;
    conta_contador = 1; tick(); tick(); tick(); conta_contador = 0;
    select_mux_pos = 2'd3; select_mux_coor = 0; select_soma_sub = 0; #1;
    checks++; if (db_contador !== 4'd3) $display("[TB] FAIL move_cnt got=%h exp=3", db_contador); else passes++;
    checks++; if (db_wire_saida_som_sub !== 5'h01) $display("[TB] FAIL move_x0 got=%h exp=01", db_wire_saida_som_sub); else passes++;
    enable_mem_aste = 1;
    tick();
    enable_mem_aste = 0;
    select_mux_pos = 2'd0; #1;
    checks++; if (db_wire_saida_som_sub !== 5'h02) $display("[TB] FAIL move_x1 got=%h exp=02", db_wire_saida_som_sub); else passes++;
    reset_reg_nave = 1;
    tick();
    reset_reg_nave = 0;
    select_mux_pos = 2'd1; select_mux_coor = 0; #1;
    checks++; if (db_wire_saida_som_sub !== 5'h08) $display("[TB] FAIL ship_rst_x got=%h exp=08", db_wire_saida_som_sub); else passes++;
    select_mux_coor = 1; #1;
    checks++; if (db_wire_saida_som_sub !== 5'h08) $display("[TB] FAIL ship_rst_y got=%h exp=08", db_wire_saida_som_sub); else passes++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      reset           = 1'b0;
      conta_contador  = 1'($urandom_range(0, 1));
      reset_cont      = ($urandom_range(0, 15) == 0);
      select_mux_pos  = 2'($urandom_range(0, 3));
      select_mux_coor = 1'($urandom_range(0, 1));
      select_soma_sub = 1'($urandom_range(0, 1));
      enable_reg_nave = 1'($urandom_range(0, 1));
      reset_reg_nave  = ($urandom_range(0, 15) == 0);
      enable_mem_aste = 1'($urandom_range(0, 1));
      enable_mem_load = ($urandom_range(0, 3) == 0);
      new_load        = ($urandom_range(0, 3) != 0);
      new_destruido   = ($urandom_range(0, 3) == 0);
      #1;
      checks++; if (db_wire_saida_som_sub !== 5'(m_sum())) $display("[TB] FAIL rnd_sum n=%0d got=%h exp=%h", n, db_wire_saida_som_sub, 5'(m_sum())); else passes++;
      checks++; if (colisao !== m_colisao()) $display("[TB] FAIL rnd_colisao n=%0d got=%b exp=%b", n, colisao, m_colisao()); else passes++;
      checks++; if (db_contador !== 4'(m_cnt)) $display("[TB] FAIL rnd_cnt n=%0d got=%h exp=%h", n, db_contador, 4'(m_cnt)); else passes++;
      checks++; if (rco_contador !== (m_cnt == 15)) $display("[TB] FAIL rnd_rco n=%0d got=%b exp=%b", n, rco_contador, (m_cnt == 15)); else passes++;
      checks++; if (opcode !== 2'(m_cnt % 4)) $display("[TB] FAIL rnd_opcode n=%0d got=%b exp=%b", n, opcode, 2'(m_cnt % 4)); else passes++;
      checks++; if (loaded !== m_ld[m_cnt]) $display("[TB] FAIL rnd_loaded n=%0d got=%b exp=%b", n, loaded, m_ld[m_cnt]); else passes++;
      checks++; if (destruido !== m_ds[m_cnt]) $display("[TB] FAIL rnd_destruido n=%0d got=%b exp=%b", n, destruido, m_ds[m_cnt]); else passes++;
      tick();
    end
  endtask

  task automatic test_mid_reset();
    reset = 1; conta_contador = 1; reset_cont = 0; select_mux_pos = 2'd3;
    select_mux_coor = 0; select_soma_sub = 0; enable_reg_nave = 1; reset_reg_nave = 0;
    enable_mem_aste = 1; enable_mem_load = 1; new_load = 1; new_destruido = 0;
    tick();
    drive_idle();
    #1;
    checks++; if (db_contador !== 4'd0) $display("[TB] FAIL mrst_cnt got=%h exp=0", db_contador); else passes++;
    select_mux_pos = 2'd1; select_mux_coor = 1; #1;
    checks++; if (db_wire_saida_som_sub !== 5'h08) $display("[TB] FAIL mrst_ship_y got=%h exp=08", db_wire_saida_som_sub); else passes++;
    select_mux_pos = 2'd0;
    for (int s = 0; s < 16; s++) begin
      select_mux_coor = 1'(s % 2); #1;
      checks++; if (loaded !== 1'b0 || destruido !== 1'b0) $display("[TB] FAIL mrst_flags%0d got=%b%b exp=00", s, loaded, destruido); else passes++;
      checks++; if (db_wire_saida_som_sub !== 5'h01) $display("[TB] FAIL mrst_pos%0d got=%h exp=01", s, db_wire_saida_som_sub); else passes++;
      conta_contador = 1; tick(); conta_contador = 0;
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired before completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      m_pos[i] = 0; m_ld[i] = 0; m_ds[i] = 0;
    end
    m_cnt = 0; m_ship = 8'h77;
    test_reset();
    test_ship_climb();
    test_collision();
    test_sub_wrap();
    test_counter();
    test_asteroid_move();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
